// File: rtl/gobang_mem_pkg.sv
// Shared types and constants for the gobang memory subsystem.
// A move is one placed stone, packed as {row, col}.
package gobang_mem_pkg;

  localparam int BOARD_DIM = 15;
  localparam int COORD_W   = 4;
  localparam int MOVE_W    = 2 * COORD_W;

  typedef struct packed {
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
  } move_t;

  localparam move_t NO_MOVE = '0;

endpackage

// File: rtl/history_reg_array.sv
// DEPTH x WIDTH register array with one write port and a combinational read port.
// It holds data only; the owning stack decides when and where to write.
module history_reg_array
  import gobang_mem_pkg::*;
#(
  parameter int WIDTH = MOVE_W,
  parameter int DEPTH = BOARD_DIM * BOARD_DIM,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             write_enable,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array is deliberately not reset; the stack never exposes an
  // entry it has not written, and leaving it out keeps this a plain register file.
  always_ff @(posedge clock) begin
    if (write_enable) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/move_history_stack.sv
// LIFO of placed-stone moves so game control can undo the most recent move.
// Owns the count pointer and sticky error flags; storage lives in history_reg_array.
module move_history_stack
  import gobang_mem_pkg::*;
#(
  parameter  int WIDTH = MOVE_W,
  parameter  int DEPTH = BOARD_DIM * BOARD_DIM,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [CW-1:0]    count_next;
  logic             overflow_next;
  logic             underflow_next;
  logic             write_enable;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    top_addr;
  logic [AW-1:0]    raddr;
  logic [WIDTH-1:0] rdata;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign top_addr = AW'(count - CW'(1));
  // Park the read address at 0 when empty so the read never leaves the array.
  assign raddr    = empty ? '0 : top_addr;
  assign data_out = empty ? '0 : rdata;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    count_next     = count;
    overflow_next  = overflow;
    underflow_next = underflow;
    write_enable   = 1'b0;
    waddr          = AW'(count);

    if (clear) begin
      count_next = '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (full) begin
            overflow_next = 1'b1;
          end else begin
            write_enable = 1'b1;
            count_next   = count + CW'(1);
          end
        end
        2'b01: begin
          if (empty) begin
            underflow_next = 1'b1;
          end else begin
            count_next = count - CW'(1);
          end
        end
        2'b11: begin
          write_enable = 1'b1;
          if (empty) begin
            // Nothing to undo: behaves as a plain push into slot 0.
            waddr      = '0;
            count_next = CW'(1);
          end else begin
            // Undo-and-replay: overwrite the top in place.
            waddr = top_addr;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_next;
      overflow  <= overflow_next;
      underflow <= underflow_next;
    end
  end

  history_reg_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clock        (clock),
    .write_enable (write_enable && !reset),
    .waddr        (waddr),
    .wdata        (data_in),
    .raddr        (raddr),
    .rdata        (rdata)
  );

endmodule
